// File: rtl/conv_sched_if.sv
// Handshake and tap-broadcast bundle between the convolution row scheduler and
// the conv-unit array / downstream row buffer.
interface conv_sched_if #(
  parameter int IMG_SIZE    = 32,
  parameter int KERNEL_SIZE = 5
);
  localparam int OUT_SIZE = IMG_SIZE - KERNEL_SIZE + 1;
  localparam int KTAPS    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IW = (IMG_SIZE    > 1) ? $clog2(IMG_SIZE)    : 1;
  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int FW = (KTAPS       > 1) ? $clog2(KTAPS)       : 1;
  localparam int OW = (OUT_SIZE    > 1) ? $clog2(OUT_SIZE)    : 1;

  logic          start;
  logic          busy;
  logic          done;
  logic          acc_clr;
  logic          mac_en;
  logic [IW-1:0] img_row;
  logic [KW-1:0] k_row;
  logic [KW-1:0] k_col;
  logic [FW-1:0] filter_idx;
  logic [OW-1:0] out_row;
  logic          row_valid;
  logic          row_ready;

  modport master (
    input  start, row_ready,
    output busy, done, acc_clr, mac_en, img_row, k_row, k_col,
           filter_idx, out_row, row_valid
  );

  modport slave (
    output start, row_ready,
    input  busy, done, acc_clr, mac_en, img_row, k_row, k_col,
           filter_idx, out_row, row_valid
  );
endinterface

// File: rtl/conv_row_scheduler.sv
// Sequences clear / accumulate / drain / output phases for each output row of a
// KxK convolution. Optional counters enabled by `define CONV_SCHED_PERF_EN.
module conv_row_scheduler #(
  parameter int IMG_SIZE     = 32,
  parameter int KERNEL_SIZE  = 5,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  conv_sched_if.master  bus
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stall
`endif
);
  localparam int OUT_SIZE = IMG_SIZE - KERNEL_SIZE + 1;
  localparam int KTAPS    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IW = (IMG_SIZE    > 1) ? $clog2(IMG_SIZE)    : 1;
  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int FW = (KTAPS       > 1) ? $clog2(KTAPS)       : 1;
  localparam int OW = (OUT_SIZE    > 1) ? $clog2(OUT_SIZE)    : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, OUTPUT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [OW-1:0] out_row_reg, out_row_next;
  logic [KW-1:0] k_row_reg, k_row_next;
  logic [KW-1:0] k_col_reg, k_col_next;
  logic [FW-1:0] tap_reg, tap_next;
  logic [3:0]    drain_reg, drain_next;
  logic          busy_reg, done_reg, acc_clr_reg, mac_en_reg, row_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      out_row_reg   <= '0;
      k_row_reg     <= '0;
      k_col_reg     <= '0;
      tap_reg       <= '0;
      drain_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      acc_clr_reg   <= 1'b0;
      mac_en_reg    <= 1'b0;
      row_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_row_reg   <= out_row_next;
      k_row_reg     <= k_row_next;
      k_col_reg     <= k_col_next;
      tap_reg       <= tap_next;
      drain_reg     <= drain_next;
      // Strobes are decoded from the next state so they leave a flop directly.
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == DONE);
      acc_clr_reg   <= (state_next == CLEAR);
      mac_en_reg    <= (state_next == ACCUM);
      row_valid_reg <= (state_next == OUTPUT);
    end
  end

  always_comb begin
    state_next   = state_reg;
    out_row_next = out_row_reg;
    k_row_next   = '0;
    k_col_next   = '0;
    tap_next     = '0;
    drain_next   = '0;
    case (state_reg)
      IDLE: begin
        out_row_next = '0;
        if (bus.start) state_next = CLEAR;
      end
      CLEAR: state_next = ACCUM;
      ACCUM: begin
        if (k_row_reg == KW'(KERNEL_SIZE - 1) && k_col_reg == KW'(KERNEL_SIZE - 1)) begin
          state_next = DRAIN;
        end else begin
          tap_next = tap_reg + 1'b1;
          if (k_col_reg == KW'(KERNEL_SIZE - 1)) begin
            k_row_next = k_row_reg + 1'b1;
          end else begin
            k_row_next = k_row_reg;
            k_col_next = k_col_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_reg == 4'(DRAIN_CYCLES - 1)) state_next = OUTPUT;
        else drain_next = drain_reg + 1'b1;
      end
      OUTPUT: begin
        if (bus.row_ready) begin
          if (out_row_reg == OW'(OUT_SIZE - 1)) begin
            state_next = DONE;
          end else begin
            out_row_next = out_row_reg + 1'b1;
            state_next   = CLEAR;
          end
        end
      end
      DONE: begin
        state_next   = IDLE;
        out_row_next = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.acc_clr    = acc_clr_reg;
  assign bus.mac_en     = mac_en_reg;
  assign bus.row_valid  = row_valid_reg;
  assign bus.out_row    = out_row_reg;
  assign bus.k_row      = k_row_reg;
  assign bus.k_col      = k_col_reg;
  assign bus.filter_idx = tap_reg;
  assign bus.img_row    = IW'(out_row_reg) + IW'(k_row_reg);

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] cyc_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
      perf_cycles   <= '0;
      perf_stall    <= '0;
    end else begin
      if (state_reg == IDLE) begin
        cyc_cnt_reg   <= '0;
        stall_cnt_reg <= '0;
      end else begin
        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
        if (state_reg == OUTPUT && !bus.row_ready) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      // The DONE cycle itself is busy, hence the +1.
      if (state_reg == DONE) begin
        perf_cycles <= cyc_cnt_reg + 1'b1;
        perf_stall  <= stall_cnt_reg;
      end
    end
  end
`endif
endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler at default parameters; cycle 1 is the
// cycle immediately after the clock edge that samples start.
module tb_conv_row_scheduler;
  localparam int K   = 5;
  localparam int KT  = 25;
  localparam int OS  = 28;
  localparam int ROW = 31;
  localparam int RUN = 869;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_sched_if #(.IMG_SIZE(32), .KERNEL_SIZE(5)) bus ();

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
  conv_row_scheduler #(.IMG_SIZE(32), .KERNEL_SIZE(5), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.master),
    .perf_cycles(perf_cycles), .perf_stall(perf_stall));
`else
  conv_row_scheduler #(.IMG_SIZE(32), .KERNEL_SIZE(5), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));
`endif

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.row_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.acc_clr, bus.mac_en, bus.row_valid} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b want=00000",
        {bus.busy, bus.done, bus.acc_clr, bus.mac_en, bus.row_valid});
    end
    checks++;
    if ({bus.out_row, bus.k_row, bus.k_col, bus.filter_idx, bus.img_row} !== '0) begin
      failures++; $display("FAIL reset_counters out_row=%0d k_row=%0d k_col=%0d fidx=%0d img_row=%0d",
        bus.out_row, bus.k_row, bus.k_col, bus.filter_idx, bus.img_row);
    end
`ifdef CONV_SCHED_PERF_EN
    checks++;
    if (perf_cycles !== 32'd0 || perf_stall !== 32'd0) begin
      failures++; $display("FAIL reset_perf cycles=%0d stall=%0d want 0/0", perf_cycles, perf_stall);
    end
`endif
    reset = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want 0", bus.busy); end
    $display("test_reset done");
  endtask

  task automatic test_full_pass();
    int rows = 0;
    int tap = 0;
    bit seen_done = 0;
    bus.row_ready = 1'b1;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    for (int cyc = 1; cyc <= 1000 && !seen_done; cyc++) begin
      checks++;
      if ($countones({bus.acc_clr, bus.mac_en, bus.row_valid, bus.done}) > 1) begin
        failures++; $display("FAIL mutex cyc=%0d acc_clr=%b mac_en=%b row_valid=%b done=%b",
          cyc, bus.acc_clr, bus.mac_en, bus.row_valid, bus.done);
      end
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy cyc=%0d got=%b want 1", cyc, bus.busy); end
      checks++;
      if (int'(bus.img_row) !== int'(bus.out_row) + int'(bus.k_row)) begin
        failures++; $display("FAIL img_row cyc=%0d got=%0d want=%0d", cyc, bus.img_row,
          int'(bus.out_row) + int'(bus.k_row));
      end
      if (bus.acc_clr) tap = 0;
      if (bus.mac_en) begin
        checks++;
        if (int'(bus.filter_idx) !== tap || int'(bus.k_row) !== tap / K || int'(bus.k_col) !== tap % K) begin
          failures++; $display("FAIL tap cyc=%0d fidx=%0d k=%0d:%0d want fidx=%0d k=%0d:%0d", cyc,
            bus.filter_idx, bus.k_row, bus.k_col, tap, tap / K, tap % K);
        end
        tap++;
      end else begin
        checks++;
        if (bus.k_row !== '0 || bus.k_col !== '0 || bus.filter_idx !== '0) begin
          failures++; $display("FAIL idle_tap cyc=%0d k=%0d:%0d fidx=%0d want 0", cyc,
            bus.k_row, bus.k_col, bus.filter_idx);
        end
      end
      if (bus.row_valid) begin
        checks++;
        if (cyc !== ROW * (rows + 1) || int'(bus.out_row) !== rows || tap !== KT) begin
          failures++; $display("FAIL row_valid cyc=%0d out_row=%0d taps=%0d want cyc=%0d out_row=%0d taps=%0d",
            cyc, bus.out_row, tap, ROW * (rows + 1), rows, KT);
        end
        $display("row %0d accepted at cycle %0d", bus.out_row, cyc);
        rows++;
      end
      if (bus.done) begin
        seen_done = 1;
        checks++;
        if (cyc !== RUN || rows !== OS) begin
          failures++; $display("FAIL done_time cyc=%0d rows=%0d want cyc=%0d rows=%0d", cyc, rows, RUN, OS);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!seen_done) begin failures++; $display("FAIL full_pass_timeout done not seen within 1000 cycles"); end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_row !== '0) begin
      failures++; $display("FAIL after_done busy=%b done=%b out_row=%0d want 0/0/0", bus.busy, bus.done, bus.out_row);
    end
`ifdef CONV_SCHED_PERF_EN
    checks++;
    if (perf_cycles !== 32'(RUN) || perf_stall !== 32'd0) begin
      failures++; $display("FAIL perf_full cycles=%0d stall=%0d want %0d/0", perf_cycles, perf_stall, RUN);
    end
`endif
    $display("test_full_pass rows=%0d", rows);
  endtask

  task automatic test_stall();
    int stalled = 0;
    int done_cyc = 0;
    bus.row_ready = 1'b1;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    for (int cyc = 1; cyc <= 1000 && done_cyc == 0; cyc++) begin
      if (bus.row_valid && bus.out_row == 5'd5 && stalled < 10) begin
        bus.row_ready = 1'b0;
        stalled++;
      end else begin
        bus.row_ready = 1'b1;
      end
      if (stalled > 0 && stalled <= 10 && bus.row_ready == 1'b0) begin
        checks++;
        if (bus.row_valid !== 1'b1 || bus.out_row !== 5'd5) begin
          failures++; $display("FAIL stall_hold cyc=%0d row_valid=%b out_row=%0d want 1/5", cyc,
            bus.row_valid, bus.out_row);
        end
      end
      if (bus.done) done_cyc = cyc;
      @(negedge clk);
    end
    bus.row_ready = 1'b1;
    checks++;
    if (done_cyc !== RUN + 10 || stalled !== 10) begin
      failures++; $display("FAIL stall_done cyc=%0d stalled=%0d want cyc=%0d stalled=10", done_cyc, stalled, RUN + 10);
    end
`ifdef CONV_SCHED_PERF_EN
    checks++;
    if (perf_stall !== 32'd10 || perf_cycles !== 32'(RUN + 10)) begin
      failures++; $display("FAIL perf_stall stall=%0d cycles=%0d want 10/%0d", perf_stall, perf_cycles, RUN + 10);
    end
`endif
    $display("test_stall done at cycle %0d", done_cyc);
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    bit repulsed = 0;
    bus.row_ready = 1'b1;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    for (int cyc = 1; cyc <= 1000 && dones == 0; cyc++) begin
      bus.start = 1'b0;
      if (bus.out_row == 5'd3 && bus.mac_en && !repulsed) begin
        bus.start = 1'b1; repulsed = 1;
      end
      if (bus.done) begin
        dones++;
        bus.start = 1'b1;
        checks++;
        if (cyc !== RUN) begin failures++; $display("FAIL repulse_done cyc=%0d want %0d", cyc, RUN); end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL repulse_timeout dones=%0d want 1", dones); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        failures++; $display("FAIL start_not_queued i=%0d busy=%b done=%b want 0/0", i, bus.busy, bus.done);
      end
      @(negedge clk);
    end
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.acc_clr !== 1'b1 || bus.out_row !== '0) begin
      failures++; $display("FAIL idle_start busy=%b acc_clr=%b out_row=%0d want 1/1/0", bus.busy, bus.acc_clr, bus.out_row);
    end
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    $display("test_start_ignored dones=%0d", dones);
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    bus.row_ready = 1'b1;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    for (int cyc = 1; cyc <= 1000 && !hit; cyc++) begin
      if (bus.out_row == 5'd12 && bus.mac_en) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL reset_mid_timeout ACCUM of row 12 not reached"); end
    reset = 1'b1; bus.start = 1'b1; @(negedge clk); reset = 1'b0; bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.acc_clr, bus.mac_en, bus.row_valid} !== 5'b0 ||
        {bus.out_row, bus.k_row, bus.k_col, bus.filter_idx, bus.img_row} !== '0) begin
      failures++; $display("FAIL reset_mid strobes=%b out_row=%0d k=%0d:%0d fidx=%0d img_row=%0d want all 0",
        {bus.busy, bus.done, bus.acc_clr, bus.mac_en, bus.row_valid}, bus.out_row, bus.k_row,
        bus.k_col, bus.filter_idx, bus.img_row);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL abort_quiet i=%0d done=%b busy=%b want 0/0", i, bus.done, bus.busy);
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.row_ready = 1'b0;
    test_reset();
    test_full_pass();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_full_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
